// File: rtl/sys_pll_div_gen.sv
// -----------------------------------------------------------------------------
// sys_pll_div_gen
// Fully digital multi-output clock divider. From one reference clock it
// produces NUM_CLOCKS divided square waves, each with a single-cycle enable
// pulse on its rising edge. Dividers can be reprogrammed at run time through
// a valid/ready handshake. A new ratio takes effect at the channel's natural
// wrap, so no runt pulse is produced. `locked` reports that every channel has
// been running at its programmed ratio for LOCK_CYCLES cycles.
//
// Ports:
//   refclk     in   sole clock, all state updates on its rising edge
//   rst        in   synchronous active-low reset
//   cfg_valid  in   divider update request
//   cfg_ready  out  an update can be accepted (single pending slot is free)
//   cfg_chan   in   target channel; out-of-range requests are accepted and dropped
//   cfg_div    in   new ratio; values 0 and 1 are stored as 2
//   cfg_phase  in   (SYS_PLL_DIV_GEN_PHASE_EN only) counter load value on apply
//   outclk     out  divided clocks, high while cnt < (div+1)>>1
//   outclk_en  out  one-cycle pulse where cnt == 0
//   locked     out  lock status
//
// Optional feature macro: SYS_PLL_DIV_GEN_PHASE_EN adds cfg_phase. On apply,
// the channel counter loads min(cfg_phase, div-1) instead of 0.
// -----------------------------------------------------------------------------
module sys_pll_div_gen #(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 42,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
`ifdef SYS_PLL_DIV_GEN_PHASE_EN
  input  logic [DIV_W-1:0]      cfg_phase,
`endif
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int              LCW     = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

  typedef enum logic {LOCKING, LOCKED} lock_state_t;

  // run_q is low for the reset cycles and the first active edge, so the
  // first cycle after release presents cnt == 0 on every channel.
  logic                             run_q;
  logic [NUM_CLOCKS-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NUM_CLOCKS-1:0][DIV_W-1:0] div_q, div_d;
  logic [NUM_CLOCKS-1:0][DIV_W:0]   half_d;
  logic [NUM_CLOCKS-1:0]            wrap, apply;
  logic [NUM_CLOCKS-1:0]            outclk_d, outclk_en_d;

  logic             pend_q, pend_d;
  logic [1:0]       pend_chan_q, pend_chan_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] pend_phase_q, pend_phase_d;
  logic [DIV_W-1:0] phase_ld;

  lock_state_t      state_q, state_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

  logic             accept_ok;
  logic             apply_any;
  logic [DIV_W-1:0] div_in;
  logic [DIV_W-1:0] phase_in;

`ifdef SYS_PLL_DIV_GEN_PHASE_EN
  assign phase_in = cfg_phase;
`else
  assign phase_in = '0;
`endif

  assign accept_ok = cfg_valid && cfg_ready && (int'(cfg_chan) < NUM_CLOCKS);
  assign div_in    = (cfg_div < TWO) ? TWO : cfg_div;
  assign phase_ld  = (pend_phase_q > pend_div_q - ONE) ? pend_div_q - ONE : pend_phase_q;
  assign apply_any = |apply;
  assign locked    = (state_q == LOCKED);

  // Channel counters. Outputs are decoded from the next counter value and
  // registered, so they line up with the counter and cannot glitch.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wrap        = '0;
    apply       = '0;
    cnt_d       = cnt_q;
    div_d       = div_q;
    half_d      = '0;
    outclk_d    = '0;
    outclk_en_d = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      wrap[i]  = (cnt_q[i] == div_q[i] - ONE);
      apply[i] = pend_q && (int'(pend_chan_q) == i) && wrap[i];
      if (!run_q)
        cnt_d[i] = '0;
      else if (wrap[i])
        cnt_d[i] = apply[i] ? phase_ld : '0;
      else
        cnt_d[i] = cnt_q[i] + ONE;
      if (apply[i])
        div_d[i] = pend_div_q;
      half_d[i]      = ({1'b0, div_d[i]} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
      outclk_d[i]    = ({1'b0, cnt_d[i]} < half_d[i]);
      outclk_en_d[i] = (cnt_d[i] == '0);
    end
  end

  // Single pending slot: filled on a valid-channel accept, emptied on apply.
  always_comb begin
    pend_d       = pend_q;
    pend_chan_d  = pend_chan_q;
    pend_div_d   = pend_div_q;
    pend_phase_d = pend_phase_q;
    if (accept_ok) begin
      pend_d       = 1'b1;
      pend_chan_d  = cfg_chan;
      pend_div_d   = div_in;
      pend_phase_d = phase_in;
    end else if (apply_any) begin
      pend_d = 1'b0;
    end
  end

  // Lock FSM. The counter is held at zero while an update waits and resumes
  // on the apply edge itself.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (!run_q) begin
      state_d    = LOCKING;
      lock_cnt_d = '0;
    end else if (accept_ok) begin
      state_d    = LOCKING;
      lock_cnt_d = '0;
    end else if (state_q == LOCKING) begin
      if (pend_q && !apply_any)
        lock_cnt_d = '0;
      else if (lock_cnt_q == LCW'(LOCK_CYCLES - 1))
        state_d = LOCKED;
      else
        lock_cnt_d = lock_cnt_q + LCW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      run_q        <= 1'b0;
      cnt_q        <= '0;
      div_q        <= {NUM_CLOCKS{DEF_DIV}};
      outclk       <= '0;
      outclk_en    <= '0;
      cfg_ready    <= 1'b0;
      pend_q       <= 1'b0;
      pend_chan_q  <= '0;
      pend_div_q   <= DEF_DIV;
      pend_phase_q <= '0;
      state_q      <= LOCKING;
      lock_cnt_q   <= '0;
    end else begin
      run_q        <= 1'b1;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      outclk       <= outclk_d;
      outclk_en    <= outclk_en_d;
      cfg_ready    <= !pend_d;
      pend_q       <= pend_d;
      pend_chan_q  <= pend_chan_d;
      pend_div_q   <= pend_div_d;
      pend_phase_q <= pend_phase_d;
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

endmodule

// File: tb/tb_sys_pll_div_gen.sv
// -----------------------------------------------------------------------------
// tb_sys_pll_div_gen
// Scoreboard bench: the stimulus thread pushes expected event cycles
// (enable pulses, outclk falling edges, locked/cfg_ready changes) into queues;
// a monitor thread pops and compares whenever the DUT shows such an event.
// Cycle 0 is the first cycle after reset release.
// -----------------------------------------------------------------------------
module tb_sys_pll_div_gen;

  localparam int NUM   = 2;
  localparam int DIV_W = 16;

  typedef struct {
    int   cyc;
    logic val;
  } lvl_ev_t;

  logic                  refclk = 1'b0;
  logic                  rst;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [1:0]            cfg_chan;
  logic [DIV_W-1:0]      cfg_div;
  logic [DIV_W-1:0]      cfg_phase;
  logic [NUM-1:0]        outclk;
  logic [NUM-1:0]        outclk_en;
  logic                  locked;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = -1;

  int      exp_en   [NUM][$];
  int      exp_fall [NUM][$];
  lvl_ev_t exp_lock [$];
  lvl_ev_t exp_rdy  [$];

  logic [NUM-1:0] prev_out;
  logic           prev_lock;
  logic           prev_rdy;
  lvl_ev_t        mon_e;
  int             mon_exp;

  sys_pll_div_gen #(
    .NUM_CLOCKS (NUM),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(42),
    .LOCK_CYCLES(16)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
`ifdef SYS_PLL_DIV_GEN_PHASE_EN
    .cfg_phase(cfg_phase),
`endif
    .outclk   (outclk),
    .outclk_en(outclk_en),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= rst ? cyc + 1 : -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, $signed(act), $signed(exp));
    end
  endtask

  // Monitor: samples 1 time unit after each active edge.
  always @(posedge refclk) begin
    #1;
    if (cyc < 0) begin
      check("reset_outclk", 32'(outclk), 32'd0);
      check("reset_outclk_en", 32'(outclk_en), 32'd0);
      check("reset_locked", 32'(locked), 32'd0);
      check("reset_cfg_ready", 32'(cfg_ready), 32'd0);
      prev_out  = '0;
      prev_lock = 1'b0;
      prev_rdy  = 1'b0;
    end else begin
      for (int ch = 0; ch < NUM; ch++) begin
        if (outclk_en[ch]) begin
          mon_exp = (exp_en[ch].size() != 0) ? exp_en[ch].pop_front() : -1;
          check($sformatf("en_pulse_ch%0d", ch), cyc, mon_exp);
          check($sformatf("outclk_high_at_en_ch%0d", ch), 32'(outclk[ch]), 32'd1);
        end
        if (prev_out[ch] && !outclk[ch]) begin
          mon_exp = (exp_fall[ch].size() != 0) ? exp_fall[ch].pop_front() : -1;
          check($sformatf("outclk_fall_ch%0d", ch), cyc, mon_exp);
        end
      end
      if (locked !== prev_lock) begin
        if (exp_lock.size() != 0) mon_e = exp_lock.pop_front();
        else mon_e = '{-1, 1'b0};
        check("locked_change_cycle", cyc, mon_e.cyc);
        check("locked_change_value", 32'(locked), 32'(mon_e.val));
      end
      if (cfg_ready !== prev_rdy) begin
        if (exp_rdy.size() != 0) mon_e = exp_rdy.pop_front();
        else mon_e = '{-1, 1'b0};
        check("ready_change_cycle", cyc, mon_e.cyc);
        check("ready_change_value", 32'(cfg_ready), 32'(mon_e.val));
      end
      prev_out  = outclk;
      prev_lock = locked;
      prev_rdy  = cfg_ready;
    end
  end

  // Expected enable pulses every `div` cycles from `first`, falling edge
  // (div+1)/2 cycles after each pulse, all up to and including `last`.
  task automatic push_chan(input int ch, input int first, input int div, input int last);
    for (int c = first; c <= last; c += div) begin
      exp_en[ch].push_back(c);
      if (c + (div + 1) / 2 <= last) exp_fall[ch].push_back(c + (div + 1) / 2);
    end
  endtask

  task automatic push_lock(input int c, input logic v);
    exp_lock.push_back('{c, v});
  endtask

  task automatic push_rdy(input int c, input logic v);
    exp_rdy.push_back('{c, v});
  endtask

  task automatic wait_cycle(input int t);
    for (int k = 0; k < 3000 && cyc != t; k++) @(negedge refclk);
    if (cyc != t) check("wait_cycle_timeout", cyc, t);
  endtask

  task automatic write_at(input int t, input logic [1:0] ch, input int div, input int phase);
    wait_cycle(t);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_div   = DIV_W'(div);
    cfg_phase = DIV_W'(phase);
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic end_segment(input string name);
    for (int ch = 0; ch < NUM; ch++) begin
      check($sformatf("%s_en_left_ch%0d", name, ch), exp_en[ch].size(), 0);
      check($sformatf("%s_fall_left_ch%0d", name, ch), exp_fall[ch].size(), 0);
      exp_en[ch].delete();
      exp_fall[ch].delete();
    end
    check({name, "_lock_left"}, exp_lock.size(), 0);
    check({name, "_ready_left"}, exp_rdy.size(), 0);
    exp_lock.delete();
    exp_rdy.delete();
  endtask

  task automatic enter_reset(input logic valid_during);
    rst       = 1'b0;
    cfg_valid = valid_during;
    cfg_chan  = 2'd0;
    cfg_div   = DIV_W'(7);
    repeat (3) @(negedge refclk);
  endtask

  initial begin
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    repeat (3) @(negedge refclk);

    // Segment 1: default run, ch1 -> 5, ch3 dropped, ch0 clamp 0 then 1.
    push_chan(0, 0, 42, 167);
    push_chan(0, 168, 2, 230);
    push_chan(1, 0, 42, 125);
    push_chan(1, 126, 5, 230);
    push_rdy(0, 1'b1);
    push_rdy(101, 1'b0);
    push_rdy(126, 1'b1);
    push_rdy(161, 1'b0);
    push_rdy(168, 1'b1);
    push_rdy(201, 1'b0);
    push_rdy(202, 1'b1);
    push_lock(16, 1'b1);
    push_lock(101, 1'b0);
    push_lock(141, 1'b1);
    push_lock(161, 1'b0);
    push_lock(183, 1'b1);
    push_lock(201, 1'b0);
    push_lock(217, 1'b1);
    rst = 1'b1;
    write_at(100, 2'd1, 5, 0);
    write_at(150, 2'd3, 9, 0);
    write_at(160, 2'd0, 0, 0);
    write_at(200, 2'd0, 1, 0);
    wait_cycle(230);
    end_segment("seg1");

    // Segment 2: reset arrives while a ch0 div=1000 update is pending.
    enter_reset(1'b0);
    push_chan(0, 0, 42, 30);
    push_chan(1, 0, 42, 30);
    push_rdy(0, 1'b1);
    push_rdy(21, 1'b0);
    push_lock(16, 1'b1);
    push_lock(21, 1'b0);
    rst = 1'b1;
    write_at(20, 2'd0, 1000, 0);
    wait_cycle(30);
    end_segment("seg2");

    // Segment 3: defaults restored, request held during reset is ignored.
    enter_reset(1'b1);
    push_chan(0, 0, 42, 90);
    push_chan(1, 0, 42, 90);
    push_rdy(0, 1'b1);
    push_lock(16, 1'b1);
    rst       = 1'b1;
    cfg_valid = 1'b0;
    wait_cycle(90);
    end_segment("seg3");

`ifdef SYS_PLL_DIV_GEN_PHASE_EN
    // Segment 4: ch1 div=42 phase=10, edges trail ch0 by 32 cycles.
    enter_reset(1'b0);
    push_chan(0, 0, 42, 180);
    push_chan(1, 0, 42, 83);
    exp_fall[1].push_back(95);
    push_chan(1, 116, 42, 180);
    push_rdy(0, 1'b1);
    push_rdy(51, 1'b0);
    push_rdy(84, 1'b1);
    push_lock(16, 1'b1);
    push_lock(51, 1'b0);
    push_lock(99, 1'b1);
    rst = 1'b1;
    write_at(50, 2'd1, 42, 10);
    wait_cycle(180);
    end_segment("seg4");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_pll_div_gen.md
Name: sys_pll_div_gen

Overview:
Parametrised, fully digital successor to the fixed single-output PLL wrapper. From one reference clock it generates NUM_CLOCKS divided clocks, each with a matching single-cycle clock-enable pulse. Each channel's divider is reprogrammable at run time through a valid/ready handshake, and the block reports a `locked` status. It sits at the top of the display pipeline and drives the slow pixel and cell-update enables.

Parameters:
- NUM_CLOCKS, 2, number of output channels (1..4)
- DIV_W, 16, divider and counter width in bits
- DEFAULT_DIV, 42, divider loaded into every channel at reset (50 MHz / 42 ≈ 1.19 MHz)
- LOCK_CYCLES, 16, stable cycles required before `locked` asserts (must be ≥ 1)

Ports:
- refclk  in  1  sole clock
- rst  in  1  synchronous, active-low reset
- cfg_valid  in  1  divider update request
- cfg_ready  out  1  block can accept an update
- cfg_chan  in  2  target channel index
- cfg_div  in  DIV_W  new divide ratio
- outclk  out  NUM_CLOCKS  divided square wave, one bit per channel
- outclk_en  out  NUM_CLOCKS  one-refclk-cycle pulse at each `outclk` rising edge
- locked  out  1  all channels running at their programmed ratio

Behaviour:
- All state is registered on the `refclk` rising edge. The `rst` check takes priority over every other action.
- Reset values, while rst=0:
  - every channel: cnt=0, div=DEFAULT_DIV
  - outclk=0, outclk_en=0, locked=0, cfg_ready=0
  - no update pending, FSM=LOCKING, lock counter=0
- Per-channel counter:
  - cnt runs 0..div-1 and then wraps to 0.
  - outclk[i]=1 while cnt < (div+1)>>1. Odd ratios therefore spend one extra cycle high.
  - outclk_en[i]=1 exactly in cycles where cnt==0.
  - Both outputs are registered, decoded from the next-cnt value, and are glitch-free.
  - In the first cycle after reset release, cnt=0, so outclk=1 and outclk_en=1.
- Divider clamp: a cfg_div of 0 or 1 is stored as 2. The maximum ratio is 2^DIV_W-1.
- Handshake:
  - An update is accepted when cfg_valid & cfg_ready.
  - cfg_ready=1 whenever no update is pending and rst=1.
  - There is a single pending slot, so cfg_ready drops in the cycle after acceptance and stays low until the update is applied.
  - cfg_chan ≥ NUM_CLOCKS: the request is accepted and discarded. Nothing becomes pending, cfg_ready stays 1, and `locked` is unaffected.
- Apply rule:
  - The pending divider is loaded at the target channel's natural wrap, i.e. the cycle where cnt==div-1 (old div).
  - The next cycle starts at cnt=0 under the new div, so there is no runt pulse.
  - Other channels are untouched.
  - cfg_ready returns to 1 in the cycle after the apply.
  - Writing the same div as the current one still goes through the pending/apply path.
- Lock FSM, states LOCKING and LOCKED:
  - LOCKING: the lock counter increments every cycle. When the counter reaches LOCK_CYCLES-1, the FSM moves to LOCKED and `locked` goes to 1.
  - With reset release counted as cycle 0, `locked`=1 first appears at cycle LOCK_CYCLES.
  - Any accepted valid-channel update forces LOCKING, clears the counter and holds `locked`=0 from the next cycle.
  - The counter stays cleared while an update is pending and starts counting in the cycle after the apply.
  - LOCKED: the FSM stays here until the next accepted valid-channel update.
- Reset mid-operation: a pending update is discarded, and every channel returns to DEFAULT_DIV with cnt=0.
- cfg_valid in the same cycle as rst=0 is ignored.

Optional Feature:
- Macro: SYS_PLL_DIV_GEN_PHASE_EN
- Defined:
  - Adds input cfg_phase [DIV_W-1:0], sampled together with cfg_div.
  - On apply, cnt is loaded with min(cfg_phase, newdiv-1) instead of 0. This delays that channel's edges relative to the other channels.
  - outclk and outclk_en decode as normal from the loaded cnt.
  - Reset phase is 0.
- Undefined: the port is absent and the phase is always 0.

Test Plan:
- Release rst, no config → outclk_en[0] and outclk_en[1] pulse at cycles 0, 42, 84. outclk high 21 cycles, low 21. locked=1 from cycle 16.
- At cycle 100 write chan=1, div=5 → cfg_ready=0 next cycle. locked=0 next cycle. Apply at the ch1 wrap (cycle 125). ch1 then runs 3 high, 2 low, with outclk_en every 5 cycles. locked=1 at 16 cycles after the apply. ch0 is unchanged.
- Write div=0, then div=1 → each clamped to 2. outclk toggles every cycle and outclk_en=1 every other cycle.
- Write chan=3 with NUM_CLOCKS=2 → cfg_ready stays 1, locked stays 1, no channel period changes.
- Drive rst=0 while a chan=0 div=1000 update is pending → after release, both channels run at 42, cfg_ready=1, and locked reasserts at cycle 16.
- With SYS_PLL_DIV_GEN_PHASE_EN defined: write chan=1, div=42, phase=10 → after the apply, ch1's outclk_en pulses occur 32 cycles after the ch0 pulse (cnt loaded at 10).
